// File: rtl/arm_multicycle_ctrl_if.sv
// Datapath control bundle between the multicycle controller and the ARM datapath.
// With ARM_MC_PERF_EN defined the bundle also carries the cycle and retired-instruction counters.
interface arm_multicycle_ctrl_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
`ifdef ARM_MC_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
`ifdef ARM_MC_PERF_EN
        , input cycle_cnt, instret_cnt
`endif
    );

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
`ifdef ARM_MC_PERF_EN
        , output cycle_cnt, instret_cnt
`endif
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Moore multicycle controller for the ARM core: decode, NZCV flags, condition check, datapath selects.
// Optional ARM_MC_PERF_EN adds free-running cycle and retired-instruction counters.
module arm_multicycle_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic                 clk,
    input logic                 reset,
    arm_multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] flags;
    logic       cond_ex_q, cond_ex;

    // Instr carries bits [31:12] of the instruction word
    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic       i_bit, sl_bit;
    logic       unused_rd;
    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign i_bit     = bus.Instr[13];
    assign cmd       = bus.Instr[12:9];
    assign sl_bit    = bus.Instr[8];
    assign unused_rd = ^bus.Instr[7:0];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = flags[3] == flags[0];
            4'b1011: cond_ex = flags[3] != flags[0];
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            flags     <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE)
                cond_ex_q <= cond_ex;
            if ((state == EXECR || state == EXECI) && sl_bit && cond_ex_q)
                flags <= bus.ALUFlags;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: case (op)
                        2'b01:   state_nxt = MEMADR;
                        2'b00:   state_nxt = i_bit ? EXECI : EXECR;
                        2'b10:   state_nxt = BRANCH;
                        default: state_nxt = FETCH;
                    endcase
            MEMADR: state_nxt = sl_bit ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            EXECR,
            EXECI:  state_nxt = ALUWB;
            default: state_nxt = FETCH;
        endcase
    end

    // CMP and unrecognised commands still run through ALUWB but never write back
    logic [1:0] alu_op;
    logic       alu_wr;
    always_comb begin
        alu_op = 2'b00;
        alu_wr = 1'b0;
        case (cmd)
            4'b0100: begin alu_op = 2'b00; alu_wr = 1'b1; end
            4'b0010: begin alu_op = 2'b01; alu_wr = 1'b1; end
            4'b0000: begin alu_op = 2'b10; alu_wr = 1'b1; end
            4'b1100: begin alu_op = 2'b11; alu_wr = 1'b1; end
            4'b1010: alu_op = 2'b01;
            default: alu_op = 2'b00;
        endcase
    end

    logic pc_we, mem_we, reg_we, ir_we;
    always_comb begin
        pc_we          = 1'b0;
        mem_we         = 1'b0;
        reg_we         = 1'b0;
        ir_we          = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 2'b00;
        bus.RegSrc     = {(op == 2'b01) && !sl_bit, 1'b0};
        bus.ImmSrc     = (op == 2'b11) ? 2'b00 : op;
        case (state)
            FETCH: begin
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
                ir_we = 1'b1; pc_we = 1'b1;
            end
            DECODE: begin
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
            end
            MEMADR: bus.ALUSrcB = 2'b01;
            MEMRD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01; reg_we = cond_ex_q;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1; mem_we = cond_ex_q;
            end
            EXECR:  bus.ALUControl = alu_op;
            EXECI: begin
                bus.ALUSrcB = 2'b01; bus.ALUControl = alu_op;
            end
            ALUWB:  reg_we = cond_ex_q & alu_wr;
            BRANCH: begin
                bus.RegSrc[0] = 1'b1; bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10;
                pc_we = cond_ex_q;
            end
            default: ;
        endcase
    end

    // Gating with reset kills any in-flight write the instant reset rises
    assign bus.PCWrite  = pc_we  & ~reset;
    assign bus.MemWrite = mem_we & ~reset;
    assign bus.RegWrite = reg_we & ~reset;
    assign bus.IRWrite  = ir_we  & ~reset;

`ifdef ARM_MC_PERF_EN
    logic retire;
    assign retire = cond_ex_q &&
                    (state == MEMWB || state == MEMWR || state == ALUWB || state == BRANCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cycle_cnt   <= 32'd0;
            bus.instret_cnt <= 32'd0;
        end else begin
            bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
            if (retire)
                bus.instret_cnt <= bus.instret_cnt + 32'd1;
        end
    end
`endif
endmodule
